// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register: state encoding and default widths.
// Imported by pipe_stage_skid and pipe_sat_counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_PERF_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous clear; sticks at all-ones.
// Latency: count visible the cycle after inc. No backpressure.
// Only the clear (rst_n) returns it to zero.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int W = DEF_PERF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with 2-entry skid buffer and synchronous flush.
// Latency: 1 cycle in to out; full throughput. Ready is registered-state only, never from Out_Ready.
// Backpressure absorbs one extra entry in the skid slot. PIPE_STAGE_PERF_EN adds Stall_Cnt/Flush_Cnt.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
   ,parameter int PERF_W = DEF_PERF_W
`endif
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [PERF_W-1:0] Stall_Cnt,
    output logic [PERF_W-1:0] Flush_Cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic out_vld;
    logic in_rdy;
    logic xfer_in;
    logic xfer_out;

    assign out_vld  = (state_q != ST_EMPTY);
    assign in_rdy   = (state_q != ST_FULL) && !Flush && Clr_n;
    assign xfer_in  = In_Valid && in_rdy;
    assign xfer_out = out_vld && Out_Ready;

    always_comb begin
        state_d     = state_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    out_ctrl_d = In_Ctrl;
                    out_data_d = In_Data;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (xfer_in && xfer_out) begin
                    out_ctrl_d = In_Ctrl;
                    out_data_d = In_Data;
                end else if (xfer_in) begin
                    skid_ctrl_d = In_Ctrl;
                    skid_data_d = In_Data;
                    state_d     = ST_FULL;
                end else if (xfer_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_out) begin
                    out_ctrl_d = skid_ctrl_q;
                    out_data_d = skid_data_q;
                    state_d    = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Squash wins; slot contents may stay stale because validity lives in the state.
        if (Flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q     <= ST_EMPTY;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign In_Ready  = in_rdy;
    assign Out_Valid = out_vld;
    // Bubbles must never carry stale write enables downstream.
    assign Out_Ctrl  = out_vld ? out_ctrl_q : '0;
    assign Out_Data  = out_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_vld && !Out_Ready;
    assign flush_inc = Flush && (state_q != ST_EMPTY);

    pipe_sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Clr_n),
        .inc   (stall_inc),
        .cnt   (Stall_Cnt)
    );

    pipe_sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Clr_n),
        .inc   (flush_inc),
        .cnt   (Flush_Cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: streaming, backpressure, flush, async reset, random traffic.
// Counter checks (incl. 4-bit saturation) are compiled in with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
`ifdef PIPE_STAGE_PERF_EN
    localparam int PW = 4;
    localparam int PMAX = (1 << PW) - 1;
`endif

    logic          Clk = 1'b0;
    logic          Clr_n = 1'b0;
    logic          Flush = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [CW-1:0] In_Ctrl = '0;
    logic [DW-1:0] In_Data = '0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b0;
    logic [CW-1:0] Out_Ctrl;
    logic [DW-1:0] Out_Data;
`ifdef PIPE_STAGE_PERF_EN
    logic [PW-1:0] Stall_Cnt;
    logic [PW-1:0] Flush_Cnt;
    int            stall_exp = 0;
    int            flush_exp = 0;
`endif

    always #5 Clk = ~Clk;

    pipe_stage_skid #(
        .DATA_W (DW),
        .CTRL_W (CW)
`ifdef PIPE_STAGE_PERF_EN
       ,.PERF_W (PW)
`endif
    ) dut (
        .Clk       (Clk),
        .Clr_n     (Clr_n),
        .Flush     (Flush),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Ctrl   (In_Ctrl),
        .In_Data   (In_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Ctrl  (Out_Ctrl),
        .Out_Data  (Out_Data)
`ifdef PIPE_STAGE_PERF_EN
       ,.Stall_Cnt (Stall_Cnt),
        .Flush_Cnt (Flush_Cnt)
`endif
    );

    logic [CW+DW-1:0] sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check just after, update the model at posedge.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        logic exp_rdy;
        logic xin;
        logic xout;
        logic [CW+DW-1:0] head;
        In_Valid  = v;
        In_Ctrl   = c;
        In_Data   = d;
        Out_Ready = ordy;
        Flush     = fl;
        #1;
        exp_rdy = (sb_q.size() < 2) && !fl;
        check("in_ready", 64'(In_Ready), 64'(exp_rdy));
        check("out_valid", 64'(Out_Valid), 64'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
            head = sb_q[0];
            check("out_data", 64'(Out_Data), 64'(head[DW-1:0]));
            check("out_ctrl", 64'(Out_Ctrl), 64'(head[CW+DW-1:DW]));
        end else begin
            check("out_ctrl_bubble", 64'(Out_Ctrl), 64'(0));
        end
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", 64'(Stall_Cnt), 64'(stall_exp));
        check("flush_cnt", 64'(Flush_Cnt), 64'(flush_exp));
        if (sb_q.size() > 0 && !ordy && stall_exp < PMAX) stall_exp++;
        if (fl && sb_q.size() > 0 && flush_exp < PMAX) flush_exp++;
`endif
        xin  = v && exp_rdy;
        xout = (sb_q.size() > 0) && ordy;
        @(posedge Clk);
        if (xout) void'(sb_q.pop_front());
        if (fl) sb_q.delete();
        if (xin) sb_q.push_back({c, d});
        @(negedge Clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_out_valid", 64'(Out_Valid), 64'(0));
        check("rst_out_ctrl", 64'(Out_Ctrl), 64'(0));
        check("rst_out_data", 64'(Out_Data), 64'(0));
        check("rst_in_ready", 64'(In_Ready), 64'(0));
        @(negedge Clk);
        Clr_n = 1'b1;

        // Streaming
        for (int i = 0; i < 8; i++) step(1'b1, CW'(i + 1), DW'(32'h11 + i), 1'b1, 1'b0);
        idle(1'b1, 2);

        // Backpressure: A consumed, B stuck in output, C in skid
        step(1'b1, 8'h0A, 32'hA, 1'b1, 1'b0);
        step(1'b1, 8'h0B, 32'hB, 1'b1, 1'b0);
        step(1'b1, 8'h0C, 32'hC, 1'b0, 1'b0);
        step(1'b1, 8'h0D, 32'hD, 1'b0, 1'b0);
        step(1'b1, 8'h0D, 32'hD, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Flush while FULL
        step(1'b1, 8'hFF, 32'h100, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 32'h101, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 32'h102, 1'b0, 1'b1);
        idle(1'b1, 1);
`ifdef PIPE_STAGE_PERF_EN
        check("flush_cnt_full", 64'(Flush_Cnt), 64'(1));
`endif

        // Flush while EMPTY
        step(1'b0, 8'hFF, 32'h0, 1'b1, 1'b1);
        idle(1'b1, 1);
`ifdef PIPE_STAGE_PERF_EN
        check("flush_cnt_empty", 64'(Flush_Cnt), 64'(1));
`endif

        // Async reset while FULL
        step(1'b1, 8'h5A, 32'h200, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 32'h201, 1'b0, 1'b0);
        In_Valid = 1'b0;
        #2;
        Clr_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(Out_Valid), 64'(0));
        check("arst_out_ctrl", 64'(Out_Ctrl), 64'(0));
        check("arst_out_data", 64'(Out_Data), 64'(0));
        check("arst_in_ready", 64'(In_Ready), 64'(0));
        sb_q.delete();
`ifdef PIPE_STAGE_PERF_EN
        stall_exp = 0;
        flush_exp = 0;
`endif
        @(negedge Clk);
        @(negedge Clk);
        Clr_n = 1'b1;
        step(1'b1, 8'h77, 32'h300, 1'b1, 1'b0);
        idle(1'b1, 2);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation
        step(1'b1, 8'h33, 32'h400, 1'b0, 1'b0);
        idle(1'b0, 20);
        check("stall_sat", 64'(Stall_Cnt), 64'(PMAX));
        idle(1'b1, 2);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
